// File: rtl/fp_round_pkg.sv
// fp_round_pkg
//   Shared constants and types for the FMUL rounding/packing pipeline and
//   its rounding-increment helper.
//   - RM_*   : rounding mode encodings carried on in_rm
//   - FLAG_* : bit positions inside the 3-bit exception flag vector
//   - cls_e  : operand class registered in stage 1
`timescale 1ns/1ps

package fp_round_pkg;

  localparam logic [1:0] RM_RNE = 2'd0;  // round to nearest, ties to even
  localparam logic [1:0] RM_RTZ = 2'd1;  // round toward zero
  localparam logic [1:0] RM_RUP = 2'd2;  // round toward +infinity
  localparam logic [1:0] RM_RDN = 2'd3;  // round toward -infinity

  localparam int FLAG_NX = 0;  // inexact
  localparam int FLAG_UF = 1;  // underflow
  localparam int FLAG_OF = 2;  // overflow

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_NAN  = 2'd2
  } cls_e;

endpackage

// File: rtl/fp_round_incr.sv
// fp_round_incr
//   Combinational rounding decision shared by the FP rounders.
//   Ports:
//     lsb     in  : least significant kept bit (L)
//     guard   in  : first discarded bit (G)
//     sticky  in  : OR of all remaining discarded bits (S)
//     sign    in  : result sign
//     rm      in  : rounding mode (RM_*)
//     inc     out : add one ulp to the kept significand
//     inexact out : discarded bits were nonzero
`timescale 1ns/1ps

module fp_round_incr
  import fp_round_pkg::*;
(
  input  logic       lsb,
  input  logic       guard,
  input  logic       sticky,
  input  logic       sign,
  input  logic [1:0] rm,
  output logic       inc,
  output logic       inexact
);

  logic inc_raw;

  // Mode-specific increment; directed modes only bump the magnitude when
  // rounding away from zero moves toward the requested infinity.
  always_comb begin
    inc_raw = 1'b0;
    case (rm)
      RM_RNE:  inc_raw = guard & (lsb | sticky);
      RM_RTZ:  inc_raw = 1'b0;
      RM_RUP:  inc_raw = ~sign;
      RM_RDN:  inc_raw = sign;
      default: inc_raw = 1'b0;
    endcase
  end

  // An exact value is never rounded, whatever the mode.
  assign inexact = guard | sticky;
  assign inc     = inc_raw & inexact;

endmodule

// File: rtl/fp_round_pipe.sv
// fp_round_pipe
//   Two-stage pipelined IEEE-754 rounding and packing unit for FMUL.
//   Stage 1 extracts kept/G/S, decides the increment and classifies the
//   operand; stage 2 performs the increment, exponent adjust, overflow
//   saturation / underflow flush and packs the result with flags.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     in_valid/in_ready   : input handshake
//     in_sign             : result sign
//     in_exp              : signed biased pre-normalised exponent (EXP_W+2)
//     in_sig              : product significand, leading one at IN_W-1
//     in_rm               : rounding mode (RM_*)
//     in_nan              : result is NaN
//     out_valid/out_ready : output handshake
//     out_result          : packed {sign, exp, frac}
//     out_flags           : {overflow, underflow, inexact}
`timescale 1ns/1ps

module fp_round_pipe
  import fp_round_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int IN_W  = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic [EXP_W+1:0]         in_exp,
  input  logic [IN_W-1:0]          in_sig,
  input  logic [1:0]               in_rm,
  input  logic                     in_nan,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_result,
  output logic [2:0]               out_flags
);

  localparam logic [EXP_W+2:0] EXP_OVF = {3'b000, {EXP_W{1'b1}}};

  // Pipeline occupancy and stage-advance control
  logic v1, v2;
  logic adv1, adv2;

  assign adv2      = ~v2 | out_ready;
  assign adv1      = ~v1 | adv2;
  assign in_ready  = adv1 & ~rst;
  assign out_valid = v2;

  // ---------------- Stage 1 combinational ----------------
  logic [MAN_W:0] kept_d;
  logic           guard_d;
  logic           sticky_d;
  logic           inc_d;
  logic           nx_d;
  cls_e           cls_d;

  assign kept_d   = in_sig[IN_W-1 -: MAN_W+1];
  assign guard_d  = in_sig[IN_W-MAN_W-2];
  assign sticky_d = |in_sig[IN_W-MAN_W-3:0];

  fp_round_incr u_incr (
    .lsb     (kept_d[0]),
    .guard   (guard_d),
    .sticky  (sticky_d),
    .sign    (in_sign),
    .rm      (in_rm),
    .inc     (inc_d),
    .inexact (nx_d)
  );

  // NaN outranks everything; a clear MSB means the product was zero.
  always_comb begin
    cls_d = CLS_NORM;
    if (in_nan)
      cls_d = CLS_NAN;
    else if (!in_sig[IN_W-1])
      cls_d = CLS_ZERO;
  end

  // ---------------- Stage 1 registers ----------------
  logic             s1_sign;
  logic [EXP_W+1:0] s1_exp;
  logic [MAN_W:0]   s1_kept;
  logic             s1_inc;
  logic             s1_nx;
  logic [1:0]       s1_rm;
  cls_e             s1_cls;

  // ---------------- Stage 2 combinational ----------------
  logic [MAN_W+1:0]    sum;
  logic                carry;
  logic [EXP_W+2:0]    exp_r;
  logic [MAN_W-1:0]    frac_r;
  logic                ovf;
  logic                udf;
  logic                sat_finite;
  logic                unused_hidden;
  logic [EXP_W+MAN_W:0] result_d;
  logic [2:0]           flags_d;

  assign sum           = {1'b0, s1_kept} + {{(MAN_W+1){1'b0}}, s1_inc};
  assign carry         = sum[MAN_W+1];
  // The hidden bit is implicit in the packed format.
  assign unused_hidden = sum[MAN_W];
  assign frac_r        = carry ? '0 : sum[MAN_W-1:0];
  // One extra bit so in_exp+1 cannot wrap before the range checks.
  assign exp_r         = {s1_exp[EXP_W+1], s1_exp} + {{(EXP_W+2){1'b0}}, carry};
  assign ovf           = $signed(exp_r) >= $signed(EXP_OVF);
  assign udf           = exp_r[EXP_W+2] | (exp_r == '0);
  // Modes that round toward zero for this sign saturate to max-finite.
  assign sat_finite    = (s1_rm == RM_RTZ) |
                         ((s1_rm == RM_RUP) & s1_sign) |
                         ((s1_rm == RM_RDN) & ~s1_sign);

  // Result selection in priority order: NaN, zero, overflow, underflow, normal.
  always_comb begin
    result_d = '0;
    flags_d  = '0;
    case (s1_cls)
      CLS_NAN: begin
        result_d = {s1_sign, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      end
      CLS_ZERO: begin
        result_d = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
      end
      default: begin
        if (ovf) begin
          flags_d[FLAG_OF] = 1'b1;
          flags_d[FLAG_NX] = 1'b1;
          if (sat_finite)
            result_d = {s1_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
          else
            result_d = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (udf) begin
          flags_d[FLAG_UF] = 1'b1;
          flags_d[FLAG_NX] = 1'b1;
          result_d = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
        end else begin
          flags_d[FLAG_NX] = s1_nx;
          result_d = {s1_sign, exp_r[EXP_W-1:0], frac_r};
        end
      end
    endcase
  end

  // Pipeline registers: each stage loads only when it advances, so a
  // stalled output holds its beat and nothing is dropped or duplicated.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      s1_sign    <= 1'b0;
      s1_exp     <= '0;
      s1_kept    <= '0;
      s1_inc     <= 1'b0;
      s1_nx      <= 1'b0;
      s1_rm      <= RM_RNE;
      s1_cls     <= CLS_ZERO;
      out_result <= '0;
      out_flags  <= '0;
    end else begin
      if (adv1) begin
        v1 <= in_valid;
        if (in_valid) begin
          s1_sign <= in_sign;
          s1_exp  <= in_exp;
          s1_kept <= kept_d;
          s1_inc  <= inc_d;
          s1_nx   <= nx_d;
          s1_rm   <= in_rm;
          s1_cls  <= cls_d;
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          out_result <= result_d;
          out_flags  <= flags_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_round_pipe.sv
`timescale 1ns/1ps

module tb_fp_round_pipe;
  import fp_round_pkg::*;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int IN_W  = 48;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [47:0] in_sig = '0;
  logic [1:0]  in_rm = '0;
  logic        in_nan = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  int checks = 0;
  int passed = 0;

  bit [31:0] res_q[$];
  bit [2:0]  fl_q[$];

  typedef struct {
    bit        sign;
    int        exp;
    bit [47:0] sig;
    bit [1:0]  rm;
    bit        nan;
    bit [31:0] res;
    bit [2:0]  fl;
  } vec_t;

  always #5 clk = ~clk;

  fp_round_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .IN_W(IN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_sig     (in_sig),
    .in_rm      (in_rm),
    .in_nan     (in_nan),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  // Collect every output beat that is handed off at the coming rising edge
  always begin
    @(negedge clk);
    #2;
    if (out_valid === 1'b1 && out_ready === 1'b1 && rst === 1'b0) begin
      res_q.push_back(out_result);
      fl_q.push_back(out_flags);
    end
  end

  // Reference model working on the numeric value of the significand
  function automatic void model(input bit sign, input int e, input bit [47:0] sig,
                                input bit [1:0] rm, input bit nan,
                                output bit [31:0] res, output bit [2:0] fl);
    longint unsigned sv, scale, kept, rem, half;
    bit inexact, up, toward_zero;
    int ex;
    sv    = 64'(sig);
    scale = 64'd1 << 24;
    half  = scale / 2;
    kept  = sv / scale;
    rem   = sv % scale;
    ex    = e;
    fl    = 3'b000;
    if (nan) begin
      res = {sign, 8'hFF, 1'b1, 22'h0};
      return;
    end
    if (sv < (64'd1 << 47)) begin
      res = {sign, 31'h0};
      return;
    end
    inexact = (rem != 0);
    case (rm)
      RM_RNE:  up = (rem > half) || (rem == half && (kept % 2) == 1);
      RM_RTZ:  up = 1'b0;
      RM_RUP:  up = inexact && !sign;
      default: up = inexact && sign;
    endcase
    kept = kept + (up ? 64'd1 : 64'd0);
    if (kept == scale) begin
      kept = kept / 2;
      ex = ex + 1;
    end
    if (ex >= 255) begin
      toward_zero = (rm == RM_RTZ) || (rm == RM_RUP && sign) || (rm == RM_RDN && !sign);
      res = toward_zero ? {sign, 8'hFE, 23'h7FFFFF} : {sign, 8'hFF, 23'h0};
      fl  = 3'b101;
    end else if (ex <= 0) begin
      res = {sign, 31'h0};
      fl  = 3'b011;
    end else begin
      res = {sign, 8'(ex), 23'(kept)};
      fl  = {2'b00, inexact};
    end
  endfunction

  // Present one beat and hold it until accepted (bounded)
  task automatic drive_beat(input bit s, input int e, input bit [47:0] sig,
                            input bit [1:0] rm, input bit nan, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = 10'(e);
    in_sig   = sig;
    in_rm    = rm;
    in_nan   = nan;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got %b want 0", in_ready);
    else passed++;
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid);
    else passed++;
    checks++;
    if (out_result !== 32'h0) $display("[TB] FAIL reset_out_result got %h want 00000000", out_result);
    else passed++;
    checks++;
    if (out_flags !== 3'b000) $display("[TB] FAIL reset_out_flags got %b want 000", out_flags);
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_release_in_ready got %b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_directed();
    vec_t dv[16];
    bit ok;
    dv[0]  = '{1'b0, 127, 48'hFFFFFF800000, RM_RNE, 1'b0, 32'h40000000, 3'b001};
    dv[1]  = '{1'b0, 127, 48'h800000800000, RM_RNE, 1'b0, 32'h3F800000, 3'b001};
    dv[2]  = '{1'b0, 127, 48'h800001800000, RM_RNE, 1'b0, 32'h3F800002, 3'b001};
    dv[3]  = '{1'b1, 127, 48'h800000000001, RM_RDN, 1'b0, 32'hBF800001, 3'b001};
    dv[4]  = '{1'b1, 127, 48'h800000000001, RM_RUP, 1'b0, 32'hBF800000, 3'b001};
    dv[5]  = '{1'b1, 127, 48'h800000000001, RM_RTZ, 1'b0, 32'hBF800000, 3'b001};
    dv[6]  = '{1'b0, 255, 48'h800000000000, RM_RNE, 1'b0, 32'h7F800000, 3'b101};
    dv[7]  = '{1'b0, 255, 48'h800000000000, RM_RTZ, 1'b0, 32'h7F7FFFFF, 3'b101};
    dv[8]  = '{1'b1, 255, 48'h800000000000, RM_RDN, 1'b0, 32'hFF800000, 3'b101};
    dv[9]  = '{1'b0, 0,   48'h800000000000, RM_RNE, 1'b0, 32'h00000000, 3'b011};
    dv[10] = '{1'b0, 127, 48'h800000000000, RM_RNE, 1'b1, 32'h7FC00000, 3'b000};
    dv[11] = '{1'b1, 127, 48'h000000000000, RM_RNE, 1'b0, 32'h80000000, 3'b000};
    dv[12] = '{1'b0, 254, 48'hFFFFFF800000, RM_RNE, 1'b0, 32'h7F800000, 3'b101};
    dv[13] = '{1'b1, 255, 48'h800000000000, RM_RUP, 1'b0, 32'hFF7FFFFF, 3'b101};
    dv[14] = '{1'b1, -1,  48'h800000000000, RM_RNE, 1'b0, 32'h80000000, 3'b011};
    dv[15] = '{1'b1, 0,   48'h000000000000, RM_RNE, 1'b1, 32'hFFC00000, 3'b000};
    out_ready = 1'b1;
    res_q.delete();
    fl_q.delete();
    for (int i = 0; i < 16; i++) begin
      drive_beat(dv[i].sign, dv[i].exp, dv[i].sig, dv[i].rm, dv[i].nan, ok);
      for (int c = 0; c < 20 && res_q.size() == 0; c++) @(negedge clk);
      checks++;
      if (!ok || res_q.size() == 0) begin
        $display("[TB] FAIL directed_%0d_timeout got %0d beats want 1", i, res_q.size());
      end else begin
        passed++;
        checks++;
        if (res_q[0] !== dv[i].res)
          $display("[TB] FAIL directed_%0d_result got %h want %h", i, res_q[0], dv[i].res);
        else passed++;
        checks++;
        if (fl_q[0] !== dv[i].fl)
          $display("[TB] FAIL directed_%0d_flags got %b want %b", i, fl_q[0], dv[i].fl);
        else passed++;
        void'(res_q.pop_front());
        void'(fl_q.pop_front());
      end
    end
  endtask

  task automatic test_random();
    bit [31:0] er[$];
    bit [2:0]  ef[$];
    bit done = 1'b0;
    int timeouts = 0;
    res_q.delete();
    fl_q.delete();
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          bit s, nan, ok;
          int e;
          bit [47:0] sig;
          bit [1:0] rm;
          bit [31:0] r;
          bit [2:0] f;
          s   = 1'($urandom_range(0, 1));
          rm  = 2'($urandom_range(0, 3));
          nan = ($urandom_range(0, 31) == 0);
          if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 5))
              0: e = -1;
              1: e = 0;
              2: e = 1;
              3: e = 254;
              4: e = 255;
              default: e = 256;
            endcase
          end else begin
            e = int'($urandom_range(1, 254));
          end
          sig = 48'({$urandom, $urandom});
          case ($urandom_range(0, 9))
            0: sig[23:0] = 24'h800000;
            1: sig[23:0] = 24'h000000;
            2: sig[47:24] = 24'hFFFFFF;
            default: ;
          endcase
          if ($urandom_range(0, 11) == 0) sig[47] = 1'b0;
          else sig[47] = 1'b1;
          model(s, e, sig, rm, nan, r, f);
          drive_beat(s, e, sig, rm, nan, ok);
          if (ok) begin
            er.push_back(r);
            ef.push_back(f);
          end else begin
            timeouts++;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    for (int c = 0; c < 2000 && res_q.size() < er.size(); c++) @(negedge clk);
    checks++;
    if (timeouts != 0 || res_q.size() != er.size())
      $display("[TB] FAIL random_count got %0d beats want %0d (accept timeouts %0d)",
               res_q.size(), er.size(), timeouts);
    else passed++;
    for (int i = 0; i < er.size() && i < res_q.size(); i++) begin
      checks++;
      if (res_q[i] !== er[i] || fl_q[i] !== ef[i])
        $display("[TB] FAIL random_%0d got %h/%b want %h/%b", i, res_q[i], fl_q[i], er[i], ef[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    bit [31:0] er[$];
    bit [2:0]  ef[$];
    int acc = 0;
    int timeouts = 0;
    bit saw_stall = 1'b0;
    bit unstable = 1'b0;
    bit have_ref = 1'b0;
    bit [31:0] ref_res = '0;
    bit [2:0]  ref_fl = '0;
    longint t0 = 0;
    longint t1 = 0;
    res_q.delete();
    fl_q.delete();
    out_ready = 1'b1;
    // Full-rate stream: 8 accepts on 8 consecutive edges
    for (int n = 0; n < 8; n++) begin
      bit ok;
      bit [47:0] sig;
      bit [31:0] r;
      bit [2:0] f;
      sig = 48'({$urandom, $urandom});
      sig[47] = 1'b1;
      model(1'b0, 100 + n, sig, RM_RNE, 1'b0, r, f);
      drive_beat(1'b0, 100 + n, sig, RM_RNE, 1'b0, ok);
      if (n == 0) t0 = $time;
      if (n == 7) t1 = $time;
      if (ok) begin
        er.push_back(r);
        ef.push_back(f);
      end else timeouts++;
    end
    checks++;
    if (t1 - t0 != 70) $display("[TB] FAIL throughput got %0d ns want 70 ns", t1 - t0);
    else passed++;
    // Stalled stream: out_ready low for 4 cycles mid-stream
    fork
      begin
        for (int n = 0; n < 8; n++) begin
          bit ok;
          bit [47:0] sig;
          bit [1:0] rm;
          bit [31:0] r;
          bit [2:0] f;
          sig = 48'({$urandom, $urandom});
          sig[47] = 1'b1;
          rm = 2'(n % 4);
          model(n[0], 120 + n, sig, rm, 1'b0, r, f);
          drive_beat(n[0], 120 + n, sig, rm, 1'b0, ok);
          if (ok) begin
            er.push_back(r);
            ef.push_back(f);
            acc++;
          end else timeouts++;
        end
      end
      begin
        for (int c = 0; c < 100 && acc < 3; c++) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          out_ready = 1'b0;
          #1;
          if (in_ready === 1'b0) saw_stall = 1'b1;
          if (out_valid === 1'b1) begin
            if (have_ref && (out_result !== ref_res || out_flags !== ref_fl)) unstable = 1'b1;
            ref_res = out_result;
            ref_fl  = out_flags;
            have_ref = 1'b1;
          end
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    checks++;
    if (saw_stall !== 1'b1) $display("[TB] FAIL stall_in_ready got 1 throughout want 0 when full");
    else passed++;
    checks++;
    if (unstable || !have_ref)
      $display("[TB] FAIL stall_hold got unstable=%0d held=%0d want 0/1", unstable, have_ref);
    else passed++;
    for (int c = 0; c < 200 && res_q.size() < er.size(); c++) @(negedge clk);
    checks++;
    if (timeouts != 0 || res_q.size() != 16)
      $display("[TB] FAIL b2b_count got %0d beats want 16 (accept timeouts %0d)", res_q.size(), timeouts);
    else passed++;
    for (int i = 0; i < er.size() && i < res_q.size(); i++) begin
      checks++;
      if (res_q[i] !== er[i] || fl_q[i] !== ef[i])
        $display("[TB] FAIL b2b_%0d got %h/%b want %h/%b", i, res_q[i], fl_q[i], er[i], ef[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_flush();
    bit ok1, ok2;
    res_q.delete();
    fl_q.delete();
    @(negedge clk);
    out_ready = 1'b0;
    drive_beat(1'b0, 127, 48'hC00000000000, RM_RNE, 1'b0, ok1);
    drive_beat(1'b1, 128, 48'hA00000000000, RM_RNE, 1'b0, ok2);
    checks++;
    if (!(ok1 && ok2)) $display("[TB] FAIL flush_accept got %0d%0d want 11", ok1, ok2);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL flush_in_ready_rst got %b want 0", in_ready);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL flush_out_valid got %b want 0", out_valid);
    else passed++;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL flush_in_ready_after got %b want 1", in_ready);
    else passed++;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (res_q.size() != 0) $display("[TB] FAIL flush_no_beats got %0d beats want 0", res_q.size());
    else passed++;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_flush();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fp_round_pipe.md
# fp_round_pipe

Parametrised, two-stage pipelined IEEE-754 rounding and packing unit for the FMUL datapath. It takes a sign, a pre-normalised biased exponent and the raw double-width product significand. It applies one of four rounding modes, adjusts the exponent on mantissa carry-out, saturates to infinity or max-finite on overflow, flushes underflow to zero, and emits the packed result with exception flags. It sits between the significand multiplier/normaliser and the FMUL result register, with valid/ready handshakes on both sides.

## Interface
- `EXP_W`, 8: exponent field width.
- `MAN_W`, 23: stored fraction width, hidden bit excluded.
- `IN_W`, 48: product significand width. Must satisfy IN_W ≥ MAN_W+3.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block accepts a beat this cycle.
- `in_sign` in 1: result sign.
- `in_exp` in EXP_W+2: signed, biased, pre-normalised exponent.
- `in_sig` in IN_W: significand with the leading 1 at bit IN_W-1. All-zero means a zero product.
- `in_rm` in 2: rounding mode. 0 = RNE, 1 = RTZ, 2 = RUP (toward +inf), 3 = RDN (toward −inf).
- `in_nan` in 1: the result is NaN.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts.
- `out_result` out 1+EXP_W+MAN_W: packed as {sign, exp, frac}.
- `out_flags` out 3: bit0 inexact, bit1 underflow, bit2 overflow.

## Operation
- Field extraction:
  - kept = in_sig[IN_W-1 -: MAN_W+1]
  - G = in_sig[IN_W-MAN_W-2]
  - S = OR of in_sig[IN_W-MAN_W-3:0]
  - L = kept[0]
  - X = G|S (inexact)
- Increment decision, gated by X:
  - RNE: G&(L|S)
  - RTZ: 0
  - RUP: ~sign&X
  - RDN: sign&X
- Increment is never applied when X=0.
- Round: sum = kept + inc, MAN_W+2 bits. If sum[MAN_W+1]=1, frac = 0 and exp_r = in_exp+1. Otherwise frac = sum[MAN_W-1:0] and exp_r = in_exp.
- Overflow (exp_r ≥ 2^EXP_W−1):
  - Flags: overflow=1, inexact=1.
  - Result is inf, except RTZ, RUP with sign=1, and RDN with sign=0, which give max-finite (exp = 2^EXP_W−2, frac all ones).
- Underflow (exp_r ≤ 0, with in_sig nonzero): signed zero, underflow=1, inexact=1. No subnormals are produced.
- Zero (in_sig MSB = 0): signed zero, flags 0.
- NaN (in_nan=1): canonical quiet NaN {in_sign, all-ones, 1, zeros}, flags 0. NaN takes priority over all other cases.
- Stage 1 registers sign, exp, kept, inc, X, rm and the class (nan/zero/normal).
- Stage 2 registers the packed result and flags.

## Timing
- Latency: 2 cycles from an accepted input (in_valid & in_ready) to out_valid.
- Throughput: 1 beat per cycle while out_ready=1.
- Stage-advance rules:
  - adv2 = ~v2 | out_ready
  - adv1 = ~v1 | adv2
  - in_ready = adv1 & ~rst
  - The in_ready path is combinational from out_ready.
- out_valid = v2.
- out_result and out_flags hold stable while out_valid & ~out_ready.
- Full-pipe stall: with v1=v2=1 and out_ready=0, in_ready=0. No beat is dropped, duplicated or reordered.
- A simultaneous output pop and input push in the same cycle is legal and keeps full rate.
- Reset values: v1=0, v2=0, out_valid=0, out_result=0, out_flags=0, in_ready=0 during rst.
- Reset mid-operation discards every in-flight beat. in_ready rises the first cycle after rst falls.
- in_* fields are only sampled on accept.

## Structure
- Package `fp_round_pkg`:
  - RM_RNE/RM_RTZ/RM_RUP/RM_RDN constants.
  - FLAG_NX/FLAG_UF/FLAG_OF bit indices.
  - Class encoding (CLS_NORM, CLS_ZERO, CLS_NAN).
- Sub-module `fp_round_incr`: combinational (L, G, S, sign, rm) → inc, inexact. It is instantiated in stage 1 and reusable by the future FADD rounder.

## Test plan
All scenarios use default parameters (FP32).
- RNE carry-out: sign=0, exp=127, in_sig=0xFFFFFF800000 → 0x40000000, flags 0b001.
- RNE tie-to-even:
  - in_sig=0x800000800000, exp=127 → 0x3F800000, nx=1.
  - in_sig=0x800001800000 → 0x3F800002.
- Directed modes: in_sig=0x800000000001, exp=127, sign=1.
  - RDN → 0xBF800001.
  - RUP → 0xBF800000.
  - RTZ → 0xBF800000.
  - All three with nx=1.
- Overflow: exp=255, in_sig=0x800000000000, sign=0.
  - RNE → 0x7F800000, flags 0b101.
  - RTZ → 0x7F7FFFFF.
  - With sign=1, RDN → 0xFF800000.
- Underflow, NaN and zero:
  - exp=0 → 0x00000000, flags 0b011.
  - in_nan=1 → 0x7FC00000.
  - in_sig=0, sign=1 → 0x80000000.
- Handshake: 8 back-to-back beats, out_ready low for 4 cycles mid-stream → in_ready drops once v1=v2=1. All 8 results arrive in order with correct values. Asserting rst for 1 cycle with 2 beats in flight → out_valid=0 next cycle, and neither beat appears.
